fpu_mul_except_pipe: RTL and testbench
======================================

Name: fpu_mul_except_pipe

Overview:
Parametrised, pipelined exception and special-case unit for the FP multiplier. It classifies both operands and the datapath's rounding status, then produces per-operation IEEE-754 flags, a special-result override and accrued sticky flags. It sits alongside the multiplier datapath and shares its valid/ready handshake. It replaces the combinational flag logic.

Parameters:
EXP_W, 8, exponent width
MAN_W, 23, stored fraction width (no hidden bit)
LATENCY, 2, pipeline stages from input handshake to output (1..4)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  operand/status valid
in_ready  out  1  unit can accept input
x_sign  in  1  operand X sign
x_exp  in  EXP_W  operand X biased exponent
x_man  in  MAN_W  operand X fraction
y_sign  in  1  operand Y sign
y_exp  in  EXP_W  operand Y biased exponent
y_man  in  MAN_W  operand Y fraction
dp_ovf  in  1  datapath: rounded exponent overflowed
dp_unf  in  1  datapath: result tiny after rounding
dp_inexact  in  1  datapath: rounding discarded nonzero bits
out_valid  out  1  result valid
out_ready  in  1  downstream accepts
special_sel  out  1  downstream muxes special_result instead of datapath result
special_result  out  1+EXP_W+MAN_W  {sign,exp,man} override value
flags  out  5  {NV,DZ,OF,UF,NX} for this operation
sticky_flags  out  5  accrued flags
flags_clear  in  1  clear sticky_flags

Behaviour:
- Reset: all stage valids, out_valid, special_sel, special_result, flags and sticky_flags = 0; in_ready = 1 from the first post-reset cycle.
- Handshake: advance = ~out_valid | out_ready. in_ready = advance. The whole pipe shifts when advance = 1; otherwise it holds. Bubbles do not collapse.
- Input transfer = in_valid & in_ready. The result appears on out_valid exactly LATENCY cycles later if unstalled. Outputs stay stable while out_valid & ~out_ready.
- Classification per operand:
  - zero: exp = 0 and man = 0.
  - subnormal: exp = 0 and man != 0.
  - inf: exp all ones and man = 0.
  - NaN: exp all ones and man != 0.
  - sNaN: NaN with man MSB = 0.
- Result sign = x_sign ^ y_sign. Qnan = {0, all ones, 1 followed by zeros}.
- Priority, first match wins:
  1. Either operand sNaN: special_sel = 1, Qnan, NV.
  2. Either operand qNaN: special_sel = 1, Qnan, no flags.
  3. zero × inf (either order): special_sel = 1, Qnan, NV.
  4. inf × anything else: special_sel = 1, signed inf, no flags (exact).
  5. zero × finite: special_sel = 1, signed zero, no flags.
  6. dp_ovf: special_sel = 1, signed inf, OF + NX.
  7. Otherwise: special_sel = 0. UF = dp_unf & dp_inexact. NX = dp_inexact.
- DZ is always 0. It is carried for flag-register compatibility.
- dp_* inputs are ignored in cases 1–5. special_result = 0 when special_sel = 0.
- Sticky update on output transfer (out_valid & out_ready):
  - sticky_next = (flags_clear ? 0 : sticky_flags) | flags.
  - flags_clear without a transfer sets sticky to 0.
  - Registered, so visible the next cycle.
- Reset mid-operation: in-flight operations are discarded, with no output and no sticky update.

Optional Feature:
FPU_MUL_DAZ_EN:
- Defined: subnormal operands are classified as signed zero before the priority chain. Subnormal × inf gives Qnan + NV; subnormal × finite gives signed zero.
- Undefined: subnormals are finite nonzero and fall through to the datapath case. Subnormal × inf gives signed inf.

Test Plan:
- LATENCY=2. X=0x00000000, Y=0x7F800000, out_ready=1 → 2 cycles later out_valid=1, special_sel=1, special_result=0x7FC00000, flags=5'b10000.
- X=0x7F800001 (sNaN), Y=0x3F800000 → 0x7FC00000, flags=5'b10000. X=0x7FC00001 (qNaN) → 0x7FC00000, flags=5'b00000.
- X=0xFF800000, Y=0x40000000 → 0xFF800000, flags=0. Normal operands with dp_ovf=1, sign 0 → 0x7F800000, flags=5'b00101. dp_unf=1, dp_inexact=1 → special_sel=0, flags=5'b00011.
- Backpressure: 3 back-to-back inputs, out_ready=0 for 4 cycles → in_ready=0 once out_valid=1; no loss; results in issue order; outputs stable while stalled.
- Sticky: issue the NV op then the OF op → sticky_flags=5'b10101. Pulse flags_clear with a concurrent NX-only transfer → sticky_flags=5'b00001 next cycle. Reset during stall → all outputs 0 next cycle.
- X=0x00000001, Y=0x7F800000: with FPU_MUL_DAZ_EN → 0x7FC00000, NV. Without → 0x7F800000, flags=0.

Source files
------------

// File: rtl/fpu_mul_except_pipe.sv
// Pipelined exception/special-case unit for the FP multiplier: classifies operands, selects special results, flags and accrues sticky flags.
// Optional macro FPU_MUL_DAZ_EN: subnormal operands are treated as signed zero.
module fpu_mul_except_pipe #(
    parameter int EXP_W   = 8,
    parameter int MAN_W   = 23,
    parameter int LATENCY = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   x_sign,
    input  logic [EXP_W-1:0]       x_exp,
    input  logic [MAN_W-1:0]       x_man,
    input  logic                   y_sign,
    input  logic [EXP_W-1:0]       y_exp,
    input  logic [MAN_W-1:0]       y_man,
    input  logic                   dp_ovf,
    input  logic                   dp_unf,
    input  logic                   dp_inexact,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   special_sel,
    output logic [EXP_W+MAN_W:0]   special_result,
    output logic [4:0]             flags,
    output logic [4:0]             sticky_flags,
    input  logic                   flags_clear
);

    localparam int RW = 1 + EXP_W + MAN_W;
    localparam int PW = 1 + RW + 5;

    logic x_man_nz, y_man_nz, x_emax, y_emax, x_ezero, y_ezero;
    logic x_zero, y_zero, x_inf, y_inf, x_snan, y_snan, x_qnan, y_qnan;
    logic r_sign;

    assign x_man_nz = |x_man;
    assign y_man_nz = |y_man;
    assign x_emax   = &x_exp;
    assign y_emax   = &y_exp;
    assign x_ezero  = ~|x_exp;
    assign y_ezero  = ~|y_exp;
`ifdef FPU_MUL_DAZ_EN
    assign x_zero   = x_ezero;
    assign y_zero   = y_ezero;
`else
    assign x_zero   = x_ezero & ~x_man_nz;
    assign y_zero   = y_ezero & ~y_man_nz;
`endif
    assign x_inf    = x_emax & ~x_man_nz;
    assign y_inf    = y_emax & ~y_man_nz;
    assign x_snan   = x_emax & x_man_nz & ~x_man[MAN_W-1];
    assign y_snan   = y_emax & y_man_nz & ~y_man[MAN_W-1];
    assign x_qnan   = x_emax & x_man[MAN_W-1];
    assign y_qnan   = y_emax & y_man[MAN_W-1];
    assign r_sign   = x_sign ^ y_sign;

    logic [RW-1:0] qnan_val, inf_val, zero_val;
    assign qnan_val = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    assign inf_val  = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    assign zero_val = {r_sign, {(EXP_W+MAN_W){1'b0}}};

    logic          sel_c;
    logic [RW-1:0] res_c;
    logic [4:0]    flg_c;

    // First match wins; dp_* only matter once both operands are finite nonzero.
    always_comb begin
        sel_c = 1'b0;
        res_c = '0;
        flg_c = '0;
        if (x_snan | y_snan) begin
            sel_c = 1'b1;
            res_c = qnan_val;
            flg_c = 5'b10000;
        end else if (x_qnan | y_qnan) begin
            sel_c = 1'b1;
            res_c = qnan_val;
        end else if ((x_zero & y_inf) | (x_inf & y_zero)) begin
            sel_c = 1'b1;
            res_c = qnan_val;
            flg_c = 5'b10000;
        end else if (x_inf | y_inf) begin
            sel_c = 1'b1;
            res_c = inf_val;
        end else if (x_zero | y_zero) begin
            sel_c = 1'b1;
            res_c = zero_val;
        end else if (dp_ovf) begin
            sel_c = 1'b1;
            res_c = inf_val;
            flg_c = 5'b00101;
        end else begin
            flg_c = {3'b000, dp_unf & dp_inexact, dp_inexact};
        end
    end

    logic [LATENCY-1:0] vld_q, vld_d;
    logic [PW-1:0]      pay_q [LATENCY];
    logic [PW-1:0]      pay_d [LATENCY];
    logic [4:0]         sticky_q, sticky_d;
    logic               advance;

    assign advance = ~vld_q[LATENCY-1] | out_ready;

    // Bubble payloads are zeroed so idle outputs read as zero.
    always_comb begin
        vld_d    = vld_q;
        pay_d    = pay_q;
        sticky_d = sticky_q;
        if (advance) begin
            vld_d[0] = in_valid;
            pay_d[0] = in_valid ? {sel_c, res_c, flg_c} : '0;
            for (int i = 1; i < LATENCY; i++) begin
                vld_d[i] = vld_q[i-1];
                pay_d[i] = pay_q[i-1];
            end
        end
        if (vld_q[LATENCY-1] & out_ready)
            sticky_d = (flags_clear ? 5'b00000 : sticky_q) | pay_q[LATENCY-1][4:0];
        else if (flags_clear)
            sticky_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q    <= '0;
            pay_q    <= '{default: '0};
            sticky_q <= '0;
        end else begin
            vld_q    <= vld_d;
            pay_q    <= pay_d;
            sticky_q <= sticky_d;
        end
    end

    assign in_ready     = advance;
    assign out_valid    = vld_q[LATENCY-1];
    assign {special_sel, special_result, flags} = pay_q[LATENCY-1];
    assign sticky_flags = sticky_q;

endmodule

// File: tb/tb_fpu_mul_except_pipe.sv
// Self-checking bench for fpu_mul_except_pipe: directed special cases, backpressure, sticky, reset, then random traffic vs a reference model.
module tb_fpu_mul_except_pipe;

    localparam int L = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] xw = '0, yw = '0;
    logic        dp_ovf = 1'b0, dp_unf = 1'b0, dp_inexact = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        special_sel;
    logic [31:0] special_result;
    logic [4:0]  flags;
    logic [4:0]  sticky_flags;
    logic        flags_clear = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fpu_mul_except_pipe #(.EXP_W(8), .MAN_W(23), .LATENCY(L)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x_sign(xw[31]), .x_exp(xw[30:23]), .x_man(xw[22:0]),
        .y_sign(yw[31]), .y_exp(yw[30:23]), .y_man(yw[22:0]),
        .dp_ovf(dp_ovf), .dp_unf(dp_unf), .dp_inexact(dp_inexact),
        .out_valid(out_valid), .out_ready(out_ready),
        .special_sel(special_sel), .special_result(special_result),
        .flags(flags), .sticky_flags(sticky_flags), .flags_clear(flags_clear)
    );

    // Reference: {sel, result[31:0], flags[4:0]} from the IEEE special-case rules.
    function automatic logic [37:0] ref_op(input logic [31:0] x, input logic [31:0] y,
                                           input logic ovf, input logic unf, input logic inx);
        int  xe = int'(x[30:23]);
        int  ye = int'(y[30:23]);
        int  xm = int'(x[22:0]);
        int  ym = int'(y[22:0]);
        bit  daz = 1'b0;
        bit  xz, yz, xi, yi, xn, yn, xsn, ysn;
        logic [31:0] qn, inf, zer;
`ifdef FPU_MUL_DAZ_EN
        daz = 1'b1;
`endif
        xz  = (xe == 0) && (xm == 0 || daz);
        yz  = (ye == 0) && (ym == 0 || daz);
        xi  = (xe == 255) && (xm == 0);
        yi  = (ye == 255) && (ym == 0);
        xn  = (xe == 255) && (xm != 0);
        yn  = (ye == 255) && (ym != 0);
        xsn = xn && (xm < 32'h400000);
        ysn = yn && (ym < 32'h400000);
        qn  = 32'h7FC00000;
        inf = {x[31] ^ y[31], 31'h7F800000};
        zer = {x[31] ^ y[31], 31'h0};
        if (xsn || ysn)                return {1'b1, qn, 5'b10000};
        if (xn || yn)                  return {1'b1, qn, 5'b00000};
        if ((xz && yi) || (xi && yz))  return {1'b1, qn, 5'b10000};
        if (xi || yi)                  return {1'b1, inf, 5'b00000};
        if (xz || yz)                  return {1'b1, zer, 5'b00000};
        if (ovf)                       return {1'b1, inf, 5'b00101};
        return {1'b0, 32'h0, 3'b000, unf & inx, inx};
    endfunction

    function automatic logic [31:0] rnd_operand();
        logic       s = 1'($urandom);
        logic [22:0] m = 23'($urandom);
        case ($urandom_range(0, 7))
            0: return {s, 31'h0};
            1: return {s, 8'h00, (m == 0) ? 23'h1 : m};
            2: return {s, 8'hFF, 23'h0};
            3: return {s, 8'hFF, 1'b1, m[21:0]};
            4: return {s, 8'hFF, 1'b0, (m[21:0] == 0) ? 22'h1 : m[21:0]};
            default: return {s, 8'($urandom_range(1, 254)), m};
        endcase
    endfunction

    logic        m_vld [L];
    logic [37:0] m_pay [L];
    logic [4:0]  m_sticky;
    logic        m_acc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic adv;
        m_acc = 1'b0;
        if (rst) begin
            for (int i = 0; i < L; i++) begin
                m_vld[i] = 1'b0;
                m_pay[i] = '0;
            end
            m_sticky = '0;
        end else begin
            if (m_vld[L-1] && out_ready)
                m_sticky = (flags_clear ? 5'b0 : m_sticky) | m_pay[L-1][4:0];
            else if (flags_clear)
                m_sticky = '0;
            adv = !m_vld[L-1] || out_ready;
            if (adv) begin
                for (int i = L-1; i > 0; i--) begin
                    m_vld[i] = m_vld[i-1];
                    m_pay[i] = m_pay[i-1];
                end
                m_vld[0] = in_valid;
                m_pay[0] = in_valid ? ref_op(xw, yw, dp_ovf, dp_unf, dp_inexact) : '0;
                m_acc    = in_valid;
            end
        end
        @(posedge clk);
        #1;
        chk("out_valid", 64'(out_valid), 64'(m_vld[L-1]));
        chk("in_ready", 64'(in_ready), 64'(!m_vld[L-1] || out_ready));
        chk("sticky", 64'(sticky_flags), 64'(m_sticky));
        if (m_vld[L-1]) begin
            chk("special_sel", 64'(special_sel), 64'(m_pay[L-1][37]));
            chk("special_result", 64'(special_result), 64'(m_pay[L-1][36:5]));
            chk("flags", 64'(flags), 64'(m_pay[L-1][4:0]));
        end
    endtask

    task automatic tp_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                         input logic ovf, input logic unf, input logic inx,
                         input logic e_sel, input logic [31:0] e_res, input logic [4:0] e_flg);
        out_ready = 1'b1;
        in_valid = 1'b1; xw = x; yw = y; dp_ovf = ovf; dp_unf = unf; dp_inexact = inx;
        step();
        in_valid = 1'b0; dp_ovf = 1'b0; dp_unf = 1'b0; dp_inexact = 1'b0;
        step();
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_sel"}, 64'(special_sel), 64'(e_sel));
        chk({tag, "_res"}, 64'(special_result), 64'(e_res));
        chk({tag, "_flags"}, 64'(flags), 64'(e_flg));
    endtask

    initial begin
        for (int i = 0; i < L; i++) begin
            m_vld[i] = 1'b0;
            m_pay[i] = '0;
        end
        m_sticky = '0;
        m_acc = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_sel", 64'(special_sel), 64'd0);
        chk("rst_res", 64'(special_result), 64'd0);
        chk("rst_flags", 64'(flags), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        tp_op("zero_x_inf", 32'h00000000, 32'h7F800000, 0, 0, 0, 1'b1, 32'h7FC00000, 5'b10000);
        tp_op("snan", 32'h7F800001, 32'h3F800000, 0, 0, 0, 1'b1, 32'h7FC00000, 5'b10000);
        tp_op("qnan", 32'h7FC00001, 32'h3F800000, 0, 0, 0, 1'b1, 32'h7FC00000, 5'b00000);
        tp_op("neg_inf", 32'hFF800000, 32'h40000000, 0, 0, 0, 1'b1, 32'hFF800000, 5'b00000);
        tp_op("ovf", 32'h3F800000, 32'h40000000, 1, 0, 1, 1'b1, 32'h7F800000, 5'b00101);
        tp_op("unf", 32'h3F800000, 32'h40000000, 0, 1, 1, 1'b0, 32'h00000000, 5'b00011);
        tp_op("zero_fin", 32'h80000000, 32'h40000000, 1, 1, 1, 1'b1, 32'h80000000, 5'b00000);
`ifdef FPU_MUL_DAZ_EN
        tp_op("daz_sub_inf", 32'h00000001, 32'h7F800000, 0, 0, 0, 1'b1, 32'h7FC00000, 5'b10000);
`else
        tp_op("sub_inf", 32'h00000001, 32'h7F800000, 0, 0, 0, 1'b1, 32'h7F800000, 5'b00000);
`endif

        // Sticky accrual and clear
        flags_clear = 1'b1;
        step();
        flags_clear = 1'b0;
        chk("sticky_cleared", 64'(sticky_flags), 64'd0);
        tp_op("st_nv", 32'h00000000, 32'h7F800000, 0, 0, 0, 1'b1, 32'h7FC00000, 5'b10000);
        tp_op("st_of", 32'h3F800000, 32'h40000000, 1, 0, 1, 1'b1, 32'h7F800000, 5'b00101);
        step();
        chk("sticky_accrued", 64'(sticky_flags), 64'h15);
        in_valid = 1'b1; xw = 32'h3F800000; yw = 32'h40000000; dp_inexact = 1'b1;
        step();
        in_valid = 1'b0; dp_inexact = 1'b0;
        step();
        flags_clear = 1'b1;
        step();
        flags_clear = 1'b0;
        chk("sticky_clear_nx", 64'(sticky_flags), 64'h01);

        // Backpressure: three back-to-back ops against a 4-cycle stall
        out_ready = 1'b0;
        in_valid = 1'b1; xw = 32'h7F800001; yw = 32'h3F800000;
        step();
        xw = 32'hFF800000; yw = 32'h40000000;
        step();
        xw = 32'h3F800000; yw = 32'h40000000; dp_ovf = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_hold_res", 64'(special_result), 64'h7FC00000);
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0; dp_ovf = 1'b0;
        for (int i = 0; i < 3; i++) step();

        // Reset during a stall
        out_ready = 1'b0;
        in_valid = 1'b1; xw = 32'hFF800000; yw = 32'h40000000;
        step();
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_stall_valid", 64'(out_valid), 64'd0);
        chk("rst_stall_res", 64'(special_result), 64'd0);
        chk("rst_stall_sticky", 64'(sticky_flags), 64'd0);
        out_ready = 1'b1;
        step();

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            if (!in_valid || m_acc) begin
                in_valid   = ($urandom_range(0, 9) < 7);
                xw         = rnd_operand();
                yw         = rnd_operand();
                dp_ovf     = ($urandom_range(0, 5) == 0);
                dp_unf     = ($urandom_range(0, 3) == 0);
                dp_inexact = ($urandom_range(0, 1) == 0);
            end
            out_ready   = ($urandom_range(0, 9) < 6);
            flags_clear = ($urandom_range(0, 15) == 0);
            rst         = (n == 300);
            step();
        end
        rst = 1'b0;
        in_valid = 1'b0;
        flags_clear = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < L + 1; i++) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
